button_debounce: RTL and testbench

- Conditions the raw active-low board keys before they reach the memory-mapped peripheral block's button read path ($4000/$4001).
- Per button, it provides:
  - metastability synchronization
  - counter-based debounce to an active-high level
  - a one-cycle press pulse
  - a sticky "pressed since last read" flag that a bus read clears.
- Runs on the same clock as the peripheral block, upstream of it.

---
 rtl/button_debounce_if.sv | 48 ++++
 rtl/button_debounce.sv | 188 ++++++++++++++++++
 tb/tb_button_debounce.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// ----------------------------------------------------------------------------
// button_debounce_if
// Bundles the per-button signals exchanged between the key conditioning block
// and whatever sits around it (peripheral read path or testbench).
//
// Parameters:
//   N_BUTTONS    number of independent button channels
//
// Signals:
//   raw_n        raw key pins, active-low, asynchronous to the block clock
//   clear_press  one-cycle pulse per channel from a bus read, clears the flag
//   level        debounced key state, active-high
//   press_pulse  one-clock pulse on each debounced press
//   press_flag   sticky "pressed since last read" flag
//   press_count  8-bit press counter per channel, channel i at [8i+7:8i]
//
// Modports:
//   master       drives raw_n/clear_press, observes the conditioned outputs
//   slave        the debouncer itself
// ----------------------------------------------------------------------------
interface button_debounce_if #(
  parameter int N_BUTTONS = 2
);
  logic [N_BUTTONS-1:0]   raw_n;
  logic [N_BUTTONS-1:0]   clear_press;
  logic [N_BUTTONS-1:0]   level;
  logic [N_BUTTONS-1:0]   press_pulse;
  logic [N_BUTTONS-1:0]   press_flag;
  logic [8*N_BUTTONS-1:0] press_count;

  modport master (
    output raw_n,
    output clear_press,
    input  level,
    input  press_pulse,
    input  press_flag,
    input  press_count
  );

  modport slave (
    input  raw_n,
    input  clear_press,
    output level,
    output press_pulse,
    output press_flag,
    output press_count
  );
endinterface

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// Conditions raw active-low board keys ahead of the peripheral button read
// path. Each channel gets a two-flop synchronizer, a counter-based debounce
// FSM producing an active-high level, a one-clock press pulse, a sticky
// pressed-since-last-read flag, and an optional 8-bit press counter.
//
// Parameters:
//   N_BUTTONS        number of independent channels
//   DEBOUNCE_CYCLES  consecutive stable clocks before level changes (2..2^CTR_W)
//   CTR_W            width of each per-channel debounce counter
//
// Ports:
//   clock            block clock, rising edge
//   nreset           asynchronous active-low reset
//   bus              button_debounce_if.slave (raw_n, clear_press in;
//                    level, press_pulse, press_flag, press_count out)
//
// Configuration macro:
//   BUTTON_PRESS_COUNT_EN  when defined, press_count counts debounced presses
//                          (8-bit wrap); otherwise press_count is tied to 0
//                          and no counter flops exist.
// ----------------------------------------------------------------------------
module button_debounce #(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CTR_W           = 16
) (
  input  logic            clock,
  input  logic            nreset,
  button_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    CHK_PRESS   = 2'd1,
    HELD        = 2'd2,
    CHK_RELEASE = 2'd3
  } state_t;

  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

  logic [N_BUTTONS-1:0]   w_level;
  logic [N_BUTTONS-1:0]   w_pulse;
  logic [N_BUTTONS-1:0]   w_flag;
  logic [8*N_BUTTONS-1:0] w_count;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : gChan
    logic             r_syncMeta;
    logic             r_syncOut;
    logic             w_s;
    state_t           r_state;
    state_t           w_nextState;
    logic [CTR_W-1:0] r_ctr;
    logic [CTR_W-1:0] w_nextCtr;
    logic             r_level;
    logic             w_nextLevel;
    logic             r_pulse;
    logic             w_nextPulse;
    logic             r_flag;

    // Two-flop synchronizer; resets to the released pin level so a reset
    // never looks like a press. w_s is the synchronized key, active-high.
    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
        r_syncMeta <= 1'b1;
        r_syncOut  <= 1'b1;
      end else begin
        r_syncMeta <= bus.raw_n[i];
        r_syncOut  <= r_syncMeta;
      end
    end

    assign w_s = ~r_syncOut;

    // Debounce state, counter, level and pulse are all registered so the
    // outputs come straight from flops and cannot glitch.
    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
        r_state <= RELEASED;
        r_ctr   <= '0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_nextState;
        r_ctr   <= w_nextCtr;
        r_level <= w_nextLevel;
        r_pulse <= w_nextPulse;
      end
    end

    // Next-state logic. The counter counts clocks for which the synchronized
    // key has disagreed with the current level; any agreement restarts it,
    // so it tops out at DEBOUNCE_CYCLES-1 and cannot wrap.
    always_comb begin
      w_nextState = r_state;
      w_nextCtr   = r_ctr;
      w_nextLevel = r_level;
      w_nextPulse = 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_s) begin
            w_nextState = CHK_PRESS;
            w_nextCtr   = CTR_ONE;
          end else begin
            w_nextCtr   = '0;
          end
        end
        CHK_PRESS: begin
          if (!w_s) begin
            w_nextState = RELEASED;
            w_nextCtr   = '0;
          end else if (r_ctr == CTR_LAST) begin
            w_nextState = HELD;
            w_nextLevel = 1'b1;
            w_nextPulse = 1'b1;
            w_nextCtr   = '0;
          end else begin
            w_nextCtr   = r_ctr + CTR_ONE;
          end
        end
        HELD: begin
          if (!w_s) begin
            w_nextState = CHK_RELEASE;
            w_nextCtr   = CTR_ONE;
          end else begin
            w_nextCtr   = '0;
          end
        end
        CHK_RELEASE: begin
          if (w_s) begin
            w_nextState = HELD;
            w_nextCtr   = '0;
          end else if (r_ctr == CTR_LAST) begin
            w_nextState = RELEASED;
            w_nextLevel = 1'b0;
            w_nextCtr   = '0;
          end else begin
            w_nextCtr   = r_ctr + CTR_ONE;
          end
        end
        default: begin
          w_nextState = RELEASED;
          w_nextCtr   = '0;
          w_nextLevel = 1'b0;
        end
      endcase
    end

    // Sticky flag keyed off the registered pulse; the set term is ORed in
    // last so a bus read landing on the same clock as a press cannot lose it.
    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
        r_flag <= 1'b0;
      end else begin
        r_flag <= r_pulse | (r_flag & ~bus.clear_press[i]);
      end
    end

`ifdef BUTTON_PRESS_COUNT_EN
    logic [7:0] r_pressCount;

    // Free-running 8-bit press counter, wraps naturally, ignores bus reads.
    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
        r_pressCount <= 8'd0;
      end else if (r_pulse) begin
        r_pressCount <= r_pressCount + 8'd1;
      end
    end

    assign w_count[8*i +: 8] = r_pressCount;
`else
    assign w_count[8*i +: 8] = 8'd0;
`endif

    assign w_level[i] = r_level;
    assign w_pulse[i] = r_pulse;
    assign w_flag[i]  = r_flag;
  end

  assign bus.level       = w_level;
  assign bus.press_pulse = w_pulse;
  assign bus.press_flag  = w_flag;
  assign bus.press_count = w_count;

endmodule

// File: tb/tb_button_debounce.sv
// ----------------------------------------------------------------------------
// tb_button_debounce
// Self-checking bench for button_debounce with DEBOUNCE_CYCLES=4. A
// behavioural model tracks, per channel, how many consecutive clocks the
// synchronized key has disagreed with the debounced level and flips the level
// once that run reaches DEBOUNCE_CYCLES. Directed steps cover idle, a clean
// press, bounce, flag clear and clear/press collision, random key activity,
// counter wrap (BUTTON_PRESS_COUNT_EN) and asynchronous reset mid-count.
// ----------------------------------------------------------------------------
module tb_button_debounce;

  localparam int N = 2;
  localparam int D = 4;

  logic clock  = 1'b0;
  logic nreset = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [1:0] mSync1;
  logic [1:0] mSync2;
  logic [1:0] mLevel;
  logic [1:0] mPulse;
  logic [1:0] mFlag;
  int         mRun   [N];
  logic [7:0] mCount [N];

  button_debounce_if #(.N_BUTTONS(N)) bus ();

  button_debounce #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(D),
    .CTR_W          (16)
  ) dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (bus)
  );

  // Free-running 100 MHz-style clock
  always #5 clock = ~clock;

  // Model reset mirrors the documented reset values
  task automatic modelReset();
    mSync1 = 2'b11;
    mSync2 = 2'b11;
    mLevel = 2'b00;
    mPulse = 2'b00;
    mFlag  = 2'b00;
    for (int i = 0; i < N; i++) begin
      mRun[i]   = 0;
      mCount[i] = 8'd0;
    end
  endtask

  // One rising edge of the model, using the inputs present before the edge
  task automatic modelEdge();
    logic [1:0] s;
    if (!nreset) begin
      modelReset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      mFlag[i] = mPulse[i] | (mFlag[i] & ~bus.clear_press[i]);
      if (mPulse[i]) mCount[i] = mCount[i] + 8'd1;
    end
    s      = ~mSync2;
    mSync2 = mSync1;
    mSync1 = bus.raw_n;
    for (int i = 0; i < N; i++) begin
      mPulse[i] = 1'b0;
      if (s[i] != mLevel[i]) begin
        mRun[i] = mRun[i] + 1;
        if (mRun[i] == D) begin
          mLevel[i] = s[i];
          mPulse[i] = s[i];
          mRun[i]   = 0;
        end
      end else begin
        mRun[i] = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every DUT output against the model
  task automatic checkOutput();
    logic [15:0] expCount;
`ifdef BUTTON_PRESS_COUNT_EN
    expCount = {mCount[1], mCount[0]};
`else
    expCount = 16'h0000;
`endif
    check("level",       16'(bus.level),       16'(mLevel));
    check("press_pulse", 16'(bus.press_pulse), 16'(mPulse));
    check("press_flag",  16'(bus.press_flag),  16'(mFlag));
    check("press_count", bus.press_count,      expCount);
  endtask

  // Hold raw/clear for a number of clocks; clear is only a one-clock pulse
  task automatic applyStimulus(input logic [1:0] raw, input logic [1:0] clr, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.raw_n       = raw;
      bus.clear_press = (c == 0) ? clr : 2'b00;
      @(posedge clock);
      modelEdge();
      #1;
      checkOutput();
    end
    bus.clear_press = 2'b00;
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge
  task automatic pulseReset();
    #2;
    nreset = 1'b0;
    modelReset();
    #1;
    checkOutput();
    check("reset_ctr_zero", 16'(dut.gChan[0].r_ctr), 16'h0000);
    applyStimulus(2'b11, 2'b00, 3);
    #2;
    nreset = 1'b1;
  endtask

  initial begin
    bus.raw_n       = 2'b11;
    bus.clear_press = 2'b00;
    modelReset();

    $display("[TB] reset and idle");
    #1;
    checkOutput();
    applyStimulus(2'b11, 2'b00, 3);
    #2;
    nreset = 1'b1;
    applyStimulus(2'b11, 2'b00, 50);

    $display("[TB] clean press on channel 0");
    applyStimulus(2'b10, 2'b00, 5);
    check("clean_not_yet", 16'(bus.level[0]), 16'h0);
    applyStimulus(2'b10, 2'b00, 1);
    check("clean_level",   16'(bus.level[0]),       16'h1);
    check("clean_pulse",   16'(bus.press_pulse[0]), 16'h1);
    check("clean_other",   16'(bus.level[1]),       16'h0);
    applyStimulus(2'b10, 2'b00, 1);
    check("clean_pulse_1clk", 16'(bus.press_pulse[0]), 16'h0);
    check("clean_flag",       16'(bus.press_flag[0]),  16'h1);

    $display("[TB] flag clear");
    applyStimulus(2'b10, 2'b01, 1);
    check("flag_cleared", 16'(bus.press_flag[0]), 16'h0);
    applyStimulus(2'b10, 2'b01, 1);

    $display("[TB] release and bounce");
    applyStimulus(2'b11, 2'b00, 10);
    applyStimulus(2'b10, 2'b00, 3);
    applyStimulus(2'b11, 2'b00, 3);
    applyStimulus(2'b10, 2'b00, 3);
    applyStimulus(2'b11, 2'b00, 3);
    check("bounce_no_level", 16'(bus.level[0]), 16'h0);
    applyStimulus(2'b10, 2'b00, 5);
    check("bounce_no_pulse_yet", 16'(bus.press_pulse[0]), 16'h0);
    applyStimulus(2'b10, 2'b00, 1);
    check("bounce_pulse", 16'(bus.press_pulse[0]), 16'h1);

    $display("[TB] clear coinciding with press pulse");
    applyStimulus(2'b10, 2'b01, 2);
    applyStimulus(2'b11, 2'b00, 10);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(2'b10, mPulse[0] ? 2'b01 : 2'b00, 1);
    end
    check("set_wins_flag", 16'(bus.press_flag[0]), 16'h1);

    $display("[TB] random key activity");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    $urandom_range(1, 8));
    end

    $display("[TB] press counter wrap");
    pulseReset();
    applyStimulus(2'b11, 2'b00, 5);
    for (int k = 0; k < 257; k++) begin
      applyStimulus(2'b01, 2'b00, 7);
      applyStimulus(2'b11, 2'b00, 7);
    end
`ifdef BUTTON_PRESS_COUNT_EN
    check("count_wrap", bus.press_count, 16'h0100);
`else
    check("count_off", bus.press_count, 16'h0000);
`endif

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(2'b10, 2'b00, 8);
    applyStimulus(2'b11, 2'b00, 2);
    pulseReset();
    check("reset_level", 16'(bus.level), 16'h0);
    check("reset_flag",  16'(bus.press_flag), 16'h0);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(2'b11, 2'b00, 1);
      check("post_reset_no_pulse", 16'(bus.press_pulse), 16'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
